divider_32bit: RTL

Multi-cycle unsigned integer divider, the inverse of the 32-bit multiplier datapath. It accepts a dividend/divisor pair over a valid/ready handshake and runs one restoring radix-2 iteration per clock. It returns quotient and remainder over a second valid/ready handshake. It sits beside the multiplier in the arithmetic unit and shares its formal-check style: quotient*divisor + remainder == dividend.

---
 rtl/div_pkg.sv | 12 +
 rtl/divider_32bit_if.sv | 31 +++
 rtl/divider_32bit_props.sv | 34 +++
 rtl/divider_32bit_step.sv | 19 +
 rtl/divider_32bit.sv | 102 ++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the radix-2 divider
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_e;

endpackage

// File: rtl/divider_32bit_if.sv
// rtl/divider_32bit_if.sv - operand and result handshakes of the divider
interface divider_32bit_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport monitor (
    input in_valid, dividend, divisor, out_ready,
    input in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divider_32bit_props.sv
// rtl/divider_32bit_props.sv - result invariant and hold-stability properties of the divider
module divider_32bit_props
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic              clk,
  input logic              rst,
  divider_32bit_if.monitor bus
);
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [2*WIDTH-1:0] recon;

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q <= '0;
      dvs_q <= '0;
    end else if (bus.in_valid && bus.in_ready) begin
      dvd_q <= bus.dividend;
      dvs_q <= bus.divisor;
    end
  end

  assign recon = (2*WIDTH)'(bus.quotient) * (2*WIDTH)'(dvs_q) + (2*WIDTH)'(bus.remainder);

  a_invariant: assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.div_by_zero) |->
      (recon == (2*WIDTH)'(dvd_q)) && (bus.remainder < dvs_q));

  a_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.quotient) && $stable(bus.remainder) && $stable(bus.div_by_zero)));
endmodule

// File: rtl/divider_32bit_step.sv
// rtl/divider_32bit_step.sv - one combinational restoring-division iteration
module divider_32bit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // One spare bit above the partial remainder keeps the borrow visible.
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {2'b00, divisor_i};
  assign q_o     = ~diff[WIDTH+1];
  assign rem_o   = q_o ? diff[WIDTH:0] : shifted[WIDTH:0];
endmodule

// File: rtl/divider_32bit.sv
// rtl/divider_32bit.sv - multi-cycle unsigned divider, one quotient bit per clock
module divider_32bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic            clk,
  input logic            rst,
  divider_32bit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   step_rem;
  logic             step_q;

  divider_32bit_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .divisor_i (dvs_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dvd_d = bus.dividend;
          dvs_d = bus.divisor;
          rem_d = '0;
          if (bus.divisor == '0) begin
            quo_d   = '1;
            rem_d   = {1'b0, bus.dividend};
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            quo_d   = '0;
            dbz_d   = 1'b0;
            cnt_d   = CW'(WIDTH - 1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // Dividend shifts out MSB-first while quotient bits shift in from the right.
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q[WIDTH-1:0];
  assign bus.div_by_zero = dbz_q;
endmodule
